// File: rtl/calculator_stage_sequencer.sv
// Front-end control stage of the calculator: debounces the board buttons and steps
// through operand A, operation select, operand B and answer display.

module calculator_stage_sequencer_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic IN_clk,
    input  logic IN_rst_n,
    input  logic IN_raw,
    output logic OUT_press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             deb;
    logic             deb_d;

    // The counter only runs while the synchronised level disagrees with the accepted one.
    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
        end else begin
            sync  <= {sync[0], IN_raw};
            deb_d <= deb;
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign OUT_press = deb & ~deb_d;
endmodule

module calculator_stage_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NUM_OPS         = 5
) (
    input  logic        IN_clk,
    input  logic        IN_rst_n,
    input  logic [15:0] IN_switches,
    input  logic        IN_center_button,
    input  logic        IN_up_button,
    input  logic        IN_down_button,
    input  logic        IN_clear_button,
    output logic [15:0] OUT_operand_a,
    output logic [15:0] OUT_operand_b,
    output logic [2:0]  OUT_operation_code,
    output logic        OUT_calc_start,
    output logic        OUT_show_16bit_input,
    output logic        OUT_show_operation,
    output logic        OUT_show_answer
);
    localparam int NUM_BTNS = 4;
    localparam logic [2:0] OP_MAX = 3'(NUM_OPS - 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ENTER_A     = 3'd1;
    localparam logic [2:0] S_SELECT_OP   = 3'd2;
    localparam logic [2:0] S_ENTER_B     = 3'd3;
    localparam logic [2:0] S_SHOW_ANSWER = 3'd4;

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_press;
    logic center_ev, up_ev, down_ev, clear_ev;

    assign btn_raw = {IN_clear_button, IN_down_button, IN_up_button, IN_center_button};

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        calculator_stage_sequencer_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .IN_clk   (IN_clk),
            .IN_rst_n (IN_rst_n),
            .IN_raw   (btn_raw[g]),
            .OUT_press(btn_press[g])
        );
    end

    assign center_ev = btn_press[0];
    assign up_ev     = btn_press[1];
    assign down_ev   = btn_press[2];
    assign clear_ev  = btn_press[3];

    logic [2:0]  state, state_nxt;
    logic [15:0] a_nxt, b_nxt;
    logic [2:0]  code_nxt;
    logic        start_nxt;

    // Clear beats everything; a center event in SELECT_OP freezes the code as it stands.
    always_comb begin
        state_nxt = state;
        a_nxt     = OUT_operand_a;
        b_nxt     = OUT_operand_b;
        code_nxt  = OUT_operation_code;
        start_nxt = 1'b0;
        if (clear_ev) begin
            state_nxt = S_IDLE;
            a_nxt     = '0;
            b_nxt     = '0;
            code_nxt  = '0;
        end else begin
            case (state)
                S_IDLE:      if (center_ev) state_nxt = S_ENTER_A;
                S_ENTER_A:   if (center_ev) begin
                                 state_nxt = S_SELECT_OP;
                                 a_nxt     = IN_switches;
                             end
                S_SELECT_OP: if (center_ev) begin
                                 state_nxt = S_ENTER_B;
                             end else if (up_ev && !down_ev) begin
                                 code_nxt = (OUT_operation_code == OP_MAX) ? 3'd0 : OUT_operation_code + 3'd1;
                             end else if (down_ev && !up_ev) begin
                                 code_nxt = (OUT_operation_code == 3'd0) ? OP_MAX : OUT_operation_code - 3'd1;
                             end
                S_ENTER_B:   if (center_ev) begin
                                 state_nxt = S_SHOW_ANSWER;
                                 b_nxt     = IN_switches;
                                 start_nxt = 1'b1;
                             end
                S_SHOW_ANSWER: if (center_ev) state_nxt = S_ENTER_A;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            state                <= S_IDLE;
            OUT_operand_a        <= '0;
            OUT_operand_b        <= '0;
            OUT_operation_code   <= '0;
            OUT_calc_start       <= 1'b0;
            OUT_show_16bit_input <= 1'b0;
            OUT_show_operation   <= 1'b0;
            OUT_show_answer      <= 1'b0;
        end else begin
            state                <= state_nxt;
            OUT_operand_a        <= a_nxt;
            OUT_operand_b        <= b_nxt;
            OUT_operation_code   <= code_nxt;
            OUT_calc_start       <= start_nxt;
            OUT_show_16bit_input <= (state_nxt == S_ENTER_A) || (state_nxt == S_ENTER_B);
            OUT_show_operation   <= (state_nxt == S_SELECT_OP);
            OUT_show_answer      <= (state_nxt == S_SHOW_ANSWER);
        end
    end
endmodule

// File: tb/tb_calculator_stage_sequencer.sv
// Bench for calculator_stage_sequencer: directed walk-through plus random button traffic,
// compared every cycle against a stage-level reference model.

module tb_calculator_stage_sequencer;
    localparam int D    = 4;
    localparam int NOPS = 5;

    logic        IN_clk   = 1'b0;
    logic        IN_rst_n = 1'b0;
    logic [15:0] sw       = '0;
    logic [3:0]  btns     = '0;   // {clear, down, up, center}
    logic [15:0] opa, opb;
    logic [2:0]  code;
    logic        start, s16, sop, sans;
    logic [2:0]  shows;
    assign shows = {s16, sop, sans};

    always #5 IN_clk = ~IN_clk;

    calculator_stage_sequencer #(.DEBOUNCE_CYCLES(D), .NUM_OPS(NOPS)) dut (
        .IN_clk              (IN_clk),
        .IN_rst_n            (IN_rst_n),
        .IN_switches         (sw),
        .IN_center_button    (btns[0]),
        .IN_up_button        (btns[1]),
        .IN_down_button      (btns[2]),
        .IN_clear_button     (btns[3]),
        .OUT_operand_a       (opa),
        .OUT_operand_b       (opb),
        .OUT_operation_code  (code),
        .OUT_calc_start      (start),
        .OUT_show_16bit_input(s16),
        .OUT_show_operation  (sop),
        .OUT_show_answer     (sans)
    );

    int checks = 0;
    int errors = 0;
    int n_start = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: stages and latched values, plus button acceptance expressed as
    // "the last D synchronised samples all disagree with the accepted level".
    typedef enum logic [2:0] {M_IDLE, M_A, M_OP, M_B, M_ANS} stage_t;
    typedef struct packed {
        stage_t      st;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  code;
        logic        start;
    } mdl_t;

    mdl_t             m;
    logic [D:0][3:0]  m_hist;
    logic [3:0]       m_deb, m_press;

    function automatic mdl_t step(mdl_t s, logic [3:0] ev, logic [15:0] swv);
        mdl_t n = s;
        n.start = 1'b0;
        if (ev[3]) begin
            n = '0;
            return n;
        end
        if (ev[0]) begin
            case (s.st)
                M_IDLE: n.st = M_A;
                M_A:    begin n.st = M_OP; n.a = swv; end
                M_OP:   n.st = M_B;
                M_B:    begin n.st = M_ANS; n.b = swv; n.start = 1'b1; end
                M_ANS:  n.st = M_A;
                default: n.st = M_IDLE;
            endcase
        end else if (s.st == M_OP && ev[1] != ev[2]) begin
            n.code = ev[1] ? 3'((s.code + 1) % NOPS) : 3'((s.code + NOPS - 1) % NOPS);
        end
        return n;
    endfunction

    function automatic logic [3:0] flips(logic [D:0][3:0] h, logic [3:0] deb);
        logic [3:0] f = '1;
        for (int b = 0; b < 4; b++)
            for (int i = 1; i <= D; i++)
                if (h[i][b] == deb[b]) f[b] = 1'b0;
        return f;
    endfunction

    always @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            m       <= '0;
            m_hist  <= '0;
            m_deb   <= '0;
            m_press <= '0;
        end else begin
            m       <= step(m, m_press, sw);
            m_hist  <= {m_hist[D-1:0], btns};
            m_deb   <= m_deb ^ flips(m_hist, m_deb);
            m_press <= flips(m_hist, m_deb) & ~m_deb;
        end
    end

    always @(negedge IN_clk) begin
        chk("operand_a", 32'(opa), 32'(m.a));
        chk("operand_b", 32'(opb), 32'(m.b));
        chk("op_code", 32'(code), 32'(m.code));
        chk("calc_start", 32'(start), 32'(m.start));
        chk("show_16bit", 32'(s16), 32'(m.st == M_A || m.st == M_B));
        chk("show_op", 32'(sop), 32'(m.st == M_OP));
        chk("show_answer", 32'(sans), 32'(m.st == M_ANS));
        if (start) n_start <= n_start + 1;
    end

    task automatic tap(input logic [3:0] mk);
        btns = mk;
        repeat (6) @(negedge IN_clk);
        btns = '0;
        repeat (8) @(negedge IN_clk);
        #1;
    endtask

    // Raw edge applied at a falling edge; counts rising edges until the show selects move.
    task automatic measure(input logic [3:0] mk, output int n);
        logic [2:0] s0;
        btns = mk;
        s0   = shows;
        n    = 0;
        while (n < 20) begin
            @(posedge IN_clk);
            #1;
            n++;
            if (shows != s0) break;
        end
    endtask

    int         lat;
    logic [3:0] mk;

    initial begin
        repeat (3) @(negedge IN_clk);
        #1;
        chk("rst_opa", 32'(opa), 32'h0);
        chk("rst_code", 32'(code), 32'h0);
        chk("rst_shows", 32'(shows), 32'h0);
        chk("rst_start", 32'(start), 32'h0);
        @(negedge IN_clk);
        IN_rst_n = 1'b1;

        tap(4'b0001);
        chk("enter_a", 32'(shows), 32'b100);
        sw = 16'h1234;
        tap(4'b0001);
        chk("latch_a", 32'(opa), 32'h1234);
        chk("sel_op", 32'(shows), 32'b010);
        tap(4'b0010);
        tap(4'b0010);
        chk("code_up2", 32'(code), 32'd2);
        tap(4'b0001);
        sw = 16'h00FF;
        tap(4'b0001);
        chk("latch_b", 32'(opb), 32'h00FF);
        chk("answer_shows", 32'(shows), 32'b001);
        chk("start_once", 32'(n_start), 32'd1);

        sw = 16'hBEEF;
        tap(4'b0010);
        tap(4'b0100);
        chk("ans_ignore_updown", 32'(code), 32'd2);
        chk("start_still_once", 32'(n_start), 32'd1);

        tap(4'b0001);
        btns = 4'b0001;
        repeat (3) @(negedge IN_clk);
        btns = '0;
        repeat (8) @(negedge IN_clk);
        #1;
        chk("glitch_no_move", 32'(shows), 32'b100);

        sw = 16'h5A5A;
        @(negedge IN_clk);
        measure(4'b0001, lat);
        chk("latency", 32'(lat), 32'd7);
        repeat (93) @(negedge IN_clk);
        btns = '0;
        repeat (8) @(negedge IN_clk);
        #1;
        chk("long_hold_one_step", 32'(shows), 32'b010);
        chk("long_hold_opa", 32'(opa), 32'h5A5A);

        tap(4'b0100);
        tap(4'b0100);
        chk("code_down_to0", 32'(code), 32'd0);
        tap(4'b0100);
        chk("wrap_down", 32'(code), 32'd4);
        tap(4'b0010);
        chk("wrap_up", 32'(code), 32'd0);
        tap(4'b0110);
        chk("up_down_same", 32'(code), 32'd0);
        for (int i = 0; i < 5; i++) begin
            sw = 16'($urandom);
            @(negedge IN_clk);
        end
        #1;
        chk("sw_ignored_a", 32'(opa), 32'h5A5A);
        chk("sw_ignored_b", 32'(opb), 32'h00FF);

        tap(4'b1000);
        tap(4'b0001);
        sw = 16'hABCD;
        tap(4'b0001);
        tap(4'b0010);
        tap(4'b0010);
        tap(4'b0010);
        chk("code3", 32'(code), 32'd3);
        chk("opa_abcd", 32'(opa), 32'hABCD);
        tap(4'b0001);
        tap(4'b1001);
        chk("clear_shows", 32'(shows), 32'b000);
        chk("clear_opa", 32'(opa), 32'h0);
        chk("clear_code", 32'(code), 32'h0);
        chk("clear_no_start", 32'(n_start), 32'd1);

        tap(4'b0001);
        tap(4'b0001);
        btns = 4'b0001;
        repeat (2) @(negedge IN_clk);
        @(posedge IN_clk);
        #2;
        IN_rst_n = 1'b0;
        #1;
        chk("async_shows", 32'(shows), 32'h0);
        chk("async_opa", 32'(opa), 32'h0);
        chk("async_code", 32'(code), 32'h0);
        repeat (2) @(negedge IN_clk);
        IN_rst_n = 1'b1;
        measure(4'b0001, lat);
        chk("stale_latency", 32'(lat), 32'd7);
        btns = '0;
        repeat (8) @(negedge IN_clk);

        for (int i = 0; i < 400; i++) begin
            mk = 4'($urandom_range(0, 15));
            if (mk[3] && $urandom_range(0, 3) != 0) mk[3] = 1'b0;
            sw   = 16'($urandom);
            btns = mk;
            repeat ($urandom_range(1, 8)) @(negedge IN_clk);
            if ($urandom_range(0, 99) == 0) begin
                @(posedge IN_clk);
                #3;
                IN_rst_n = 1'b0;
                @(negedge IN_clk);
                IN_rst_n = 1'b1;
            end
        end
        btns = '0;
        repeat (10) @(negedge IN_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
